mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between the fetch stage (IF) and the load/store stage (DM) of the pipelined CPU.
- Grants one access at a time and sequences the fixed memory latency.
- Returns registered read data and drives per-requester stall signals back to the pipeline.
- DM has priority over IF; a starvation counter guarantees forward progress for fetch.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 2, cycles from issue edge until mem_rdata is valid; legal 1..15
- STARVE_LIMIT, 2, consecutive lost tie-breaks after which IF wins the next tie; legal 1..15

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DW  fetched instruction
- if_stall  out  1  fetch must hold
- dm_req  in  1  load/store request; held with dm_we, dm_addr, dm_wdata until dm_gnt
- dm_we  in  1  1 = store
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_gnt  out  1  DM accepted this cycle
- dm_rvalid  out  1  one-cycle completion pulse for loads and stores
- dm_rdata  out  DW  load data; 0 for stores
- dm_stall  out  1  memory stage must hold
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, owner=IF, lat_cnt=0, starve_cnt=0.
  - All registered outputs (if_rvalid, dm_rvalid, if_rdata, dm_rdata) = 0.
  - mem_en, mem_we, if_gnt and dm_gnt = 0 while rst_n=0.
- States: IDLE, BUSY.
- IDLE arbitration (combinational grant):
  - Only dm_req: DM wins.
  - Only if_req: IF wins.
  - Both, and starve_cnt == STARVE_LIMIT: IF wins.
  - Both, otherwise: DM wins.
  - The winner's gnt = 1 in the same cycle (cycle t). Issue in that cycle: mem_en=1, mem_addr = winner address.
  - If DM wins: mem_we = dm_we and mem_wdata = dm_wdata. If IF wins: mem_we=0 and mem_wdata=0.
  - Rising edge ending cycle t: state→BUSY, owner ← winner, lat_cnt ← MEM_LAT.
- starve_cnt:
  - +1 on each grant to DM while if_req=1 (saturates at STARVE_LIMIT).
  - Cleared on any grant to IF.
  - Unchanged otherwise.
- BUSY:
  - Spans cycles t+1 .. t+MEM_LAT; mem_en=0, mem_we=0, no grants.
  - lat_cnt decrements each edge.
  - In cycle t+MEM_LAT (lat_cnt==1), the arbiter samples mem_rdata at the ending edge and returns to IDLE.
- Completion, cycle t+MEM_LAT+1:
  - The owner's rvalid = 1 for exactly one cycle.
  - Its rdata = the sampled mem_rdata, or 0 for a store.
  - rdata holds its value until the next completion to that requester.
  - A new grant may issue in this same cycle (back-to-back).
  - Access period is MEM_LAT+1 cycles.
- Stalls (combinational):
  - if_stall = (if_req & ~if_gnt) | (state==BUSY & owner==IF).
  - dm_stall likewise for DM.
  - Both are 0 in the rvalid cycle unless the requester's new request is not granted.
- Boundary cases:
  - Request deasserted before grant: no effect.
  - Request deasserted or changed during BUSY: ignored; the access completes and rvalid still pulses.
  - Reset during BUSY: the access is abandoned, no rvalid is ever issued for it, and the arbiter restarts in IDLE.
  - No requests in IDLE: all outputs idle and starve_cnt is unchanged.

Test Plan:
- MEM_LAT=2, rst_n released, if_req=1, if_addr=0x10, memory returns 0x8C220004 → if_gnt and mem_en at cycle 0 with mem_addr=0x10; if_rvalid=1 at cycle 3 with if_rdata=0x8C220004; if_stall=1 during cycles 1-2.
- dm_req, dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF → at the grant cycle mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF; dm_rvalid=1 with dm_rdata=0 three cycles later.
- if_req and dm_req held continuously with STARVE_LIMIT=2 → grant order DM, DM, IF, DM, DM, IF; starve_cnt reads 0,1,2,0,...
- Back-to-back DM loads to 0x0 then 0x4 → second dm_gnt in the same cycle as the first dm_rvalid; issue cycles are 0 and 3.
- rst_n driven low in cycle 1 of a BUSY fetch → no if_rvalid occurs; after release, a fresh if_req is granted immediately with starve_cnt=0.
- MEM_LAT=1, single load → dm_rvalid at cycle 2; lat_cnt wraps correctly with no extra BUSY cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF/DM requester handshakes and the shared memory port.
// The arbiter connects through the slave modport; requesters and memory use master.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  // Fetch requester
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          if_stall;

  // Load/store requester
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          dm_stall;

  // Shared memory port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_stall,
    output dm_gnt, dm_rvalid, dm_rdata, dm_stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_stall,
    input  dm_gnt, dm_rvalid, dm_rdata, dm_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single data-memory port shared between fetch (IF) and load/store (DM).
// DM has priority; after STARVE_LIMIT consecutive lost ties IF wins the next tie.
// Each access occupies the port for MEM_LAT+1 cycles (issue + MEM_LAT wait),
// with the completion cycle able to issue the next access back-to-back.
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MEM_LAT      = 2,
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;
  typedef enum logic [0:0] {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_e;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          store_q, store_d;
  logic [3:0]    lat_cnt_q, lat_cnt_d;
  logic [3:0]    starve_cnt_q, starve_cnt_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          dm_rvalid_q, dm_rvalid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;

  logic          if_gnt_s, dm_gnt_s;
  logic          mem_en_s, mem_we_s;
  logic [AW-1:0] mem_addr_s;
  logic [DW-1:0] mem_wdata_s;

  // State register, latency/starvation counters and registered read returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IF;
      store_q      <= 1'b0;
      lat_cnt_q    <= 4'd0;
      starve_cnt_q <= 4'd0;
      if_rvalid_q  <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      if_rdata_q   <= {DW{1'b0}};
      dm_rdata_q   <= {DW{1'b0}};
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      store_q      <= store_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      if_rvalid_q  <= if_rvalid_d;
      dm_rvalid_q  <= dm_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  // Arbitration and issue in IDLE, latency countdown and completion in BUSY.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    store_d      = store_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    if_rvalid_d  = 1'b0;
    dm_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_gnt_s     = 1'b0;
    dm_gnt_s     = 1'b0;
    mem_en_s     = 1'b0;
    mem_we_s     = 1'b0;
    mem_addr_s   = {AW{1'b0}};
    mem_wdata_s  = {DW{1'b0}};

    case (state_q)
      ST_IDLE: begin
        // DM wins unless it is a tie and fetch has already lost STARVE_LIMIT ties.
        if (bus.dm_req && (!bus.if_req || (starve_cnt_q != STARVE_MAX))) begin
          dm_gnt_s    = 1'b1;
          mem_en_s    = 1'b1;
          mem_we_s    = bus.dm_we;
          mem_addr_s  = bus.dm_addr;
          mem_wdata_s = bus.dm_wdata;
          state_d     = ST_BUSY;
          owner_d     = OWN_DM;
          store_d     = bus.dm_we;
          lat_cnt_d   = LAT_INIT;
          if (bus.if_req && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end else begin
            starve_cnt_d = starve_cnt_q;
          end
        end else if (bus.if_req) begin
          if_gnt_s     = 1'b1;
          mem_en_s     = 1'b1;
          mem_addr_s   = bus.if_addr;
          state_d      = ST_BUSY;
          owner_d      = OWN_IF;
          store_d      = 1'b0;
          lat_cnt_d    = LAT_INIT;
          starve_cnt_d = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        // Last wait cycle: capture memory data and hand the port back.
        if (lat_cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_DM) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = store_q ? {DW{1'b0}} : bus.mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.mem_rdata;
          end
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Grants and memory strobes are forced inactive while reset is asserted.
  assign bus.if_gnt    = if_gnt_s & rst_n;
  assign bus.dm_gnt    = dm_gnt_s & rst_n;
  assign bus.mem_en    = mem_en_s & rst_n;
  assign bus.mem_we    = mem_we_s & rst_n;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_wdata = mem_wdata_s;

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

  // A requester stalls while waiting for a grant or while its own access is in flight.
  assign bus.if_stall = (bus.if_req & ~bus.if_gnt) |
                        ((state_q == ST_BUSY) & (owner_q == OWN_IF));
  assign bus.dm_stall = (bus.dm_req & ~bus.dm_gnt) |
                        ((state_q == ST_BUSY) & (owner_q == OWN_DM));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a timeline-based reference model.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int LIM = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_LIMIT(LIM)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: the port is a timeline. An access issued in cycle t owns
  // the port until cycle t+LAT, memory data is taken in cycle t+LAT and the
  // owner sees its rvalid in cycle t+LAT+1, which is also the next free cycle.
  int          cyc       = 0;
  int          free_at   = 0;
  int          issue_cyc = -100;
  int          done_at   = -1;
  int          starve    = 0;
  bit          own_dm    = 1'b0;
  bit          own_store = 1'b0;
  logic [31:0] cap       = 32'd0;
  logic [31:0] exp_if_rd = 32'd0;
  logic [31:0] exp_dm_rd = 32'd0;

  logic        snap_if_gnt, snap_dm_gnt, snap_if_rvalid, snap_dm_rvalid;
  logic        snap_if_stall, snap_dm_stall, snap_mem_en, snap_mem_we;
  logic [31:0] snap_mem_addr, snap_mem_wdata, snap_if_rdata, snap_dm_rdata;
  bit          order_q[$];

  task automatic model_step();
    bit eg_if, eg_dm, busy, fin;
    snap_if_gnt    = bus.if_gnt;    snap_dm_gnt    = bus.dm_gnt;
    snap_if_rvalid = bus.if_rvalid; snap_dm_rvalid = bus.dm_rvalid;
    snap_if_stall  = bus.if_stall;  snap_dm_stall  = bus.dm_stall;
    snap_mem_en    = bus.mem_en;    snap_mem_we    = bus.mem_we;
    snap_mem_addr  = bus.mem_addr;  snap_mem_wdata = bus.mem_wdata;
    snap_if_rdata  = bus.if_rdata;  snap_dm_rdata  = bus.dm_rdata;
    if (!rst_n) begin
      check_val("rst_if_gnt", snap_if_gnt, 32'd0);
      check_val("rst_dm_gnt", snap_dm_gnt, 32'd0);
      check_val("rst_mem_en", snap_mem_en, 32'd0);
      check_val("rst_mem_we", snap_mem_we, 32'd0);
      check_val("rst_if_rvalid", snap_if_rvalid, 32'd0);
      check_val("rst_dm_rvalid", snap_dm_rvalid, 32'd0);
      check_val("rst_if_rdata", snap_if_rdata, 32'd0);
      check_val("rst_dm_rdata", snap_dm_rdata, 32'd0);
      check_val("rst_if_stall", snap_if_stall, 32'(bus.if_req));
      check_val("rst_dm_stall", snap_dm_stall, 32'(bus.dm_req));
      free_at = 0; issue_cyc = -100; done_at = -1; starve = 0;
      exp_if_rd = 32'd0; exp_dm_rd = 32'd0;
    end else begin
      busy  = (cyc < free_at);
      eg_if = 1'b0;
      eg_dm = 1'b0;
      if (!busy) begin
        if (bus.dm_req && bus.if_req) begin
          if (starve == LIM) eg_if = 1'b1; else eg_dm = 1'b1;
        end else if (bus.dm_req) begin
          eg_dm = 1'b1;
        end else if (bus.if_req) begin
          eg_if = 1'b1;
        end
      end
      fin = (done_at == cyc);
      if (fin && own_dm) exp_dm_rd = own_store ? 32'd0 : cap;
      if (fin && !own_dm) exp_if_rd = cap;
      check_val("if_gnt", snap_if_gnt, 32'(eg_if));
      check_val("dm_gnt", snap_dm_gnt, 32'(eg_dm));
      check_val("mem_en", snap_mem_en, 32'(eg_if | eg_dm));
      check_val("mem_we", snap_mem_we, 32'(eg_dm & bus.dm_we));
      if (eg_if || eg_dm) begin
        check_val("mem_addr", snap_mem_addr, eg_dm ? bus.dm_addr : bus.if_addr);
        check_val("mem_wdata", snap_mem_wdata, eg_dm ? bus.dm_wdata : 32'd0);
      end
      check_val("if_rvalid", snap_if_rvalid, 32'(fin && !own_dm));
      check_val("dm_rvalid", snap_dm_rvalid, 32'(fin && own_dm));
      check_val("if_rdata", snap_if_rdata, exp_if_rd);
      check_val("dm_rdata", snap_dm_rdata, exp_dm_rd);
      check_val("if_stall", snap_if_stall, 32'((bus.if_req && !eg_if) || (busy && !own_dm)));
      check_val("dm_stall", snap_dm_stall, 32'((bus.dm_req && !eg_dm) || (busy && own_dm)));
      if (busy && (cyc == issue_cyc + LAT)) begin
        cap     = bus.mem_rdata;
        done_at = cyc + 1;
      end
      if (eg_if || eg_dm) begin
        issue_cyc = cyc;
        free_at   = cyc + LAT + 1;
        own_dm    = eg_dm;
        own_store = eg_dm && bus.dm_we;
        if (eg_if) starve = 0;
        else if (bus.if_req && (starve < LIM)) starve++;
      end
    end
    cyc++;
  endtask

  // One clock cycle: check at the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    bus.mem_rdata = $urandom();
  endtask

  // Hold both requests for n cycles, recording grant order (1 = DM, 0 = IF).
  task automatic hold_both(input int n);
    order_q.delete();
    bus.if_req = 1'b1;
    bus.dm_req = 1'b1;
    bus.dm_we  = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (snap_dm_gnt) begin order_q.push_back(1'b1); bus.dm_addr = $urandom(); end
      if (snap_if_gnt) begin order_q.push_back(1'b0); bus.if_addr = $urandom(); end
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_order[6];
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    bus.dm_addr = 32'd0; bus.dm_wdata = 32'd0; bus.mem_rdata = 32'd0;
    bus1.if_req = 1'b0; bus1.if_addr = 32'd0; bus1.dm_req = 1'b0; bus1.dm_we = 1'b0;
    bus1.dm_addr = 32'd0; bus1.dm_wdata = 32'd0; bus1.mem_rdata = 32'd0;
    bus.if_req = 1'b1;
    tick(); tick();
    bus.if_req = 1'b0;
    rst_n = 1'b1;

    // Single fetch from 0x10.
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    tick();
    check_val("fetch_gnt", snap_if_gnt, 32'd1);
    check_val("fetch_addr", snap_mem_addr, 32'h10);
    bus.if_req = 1'b0;
    tick();
    check_val("fetch_stall_c1", snap_if_stall, 32'd1);
    bus.mem_rdata = 32'h8C22_0004;
    tick();
    check_val("fetch_stall_c2", snap_if_stall, 32'd1);
    tick();
    check_val("fetch_rvalid", snap_if_rvalid, 32'd1);
    check_val("fetch_rdata", snap_if_rdata, 32'h8C22_0004);

    // Store to 0x40.
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'hDEAD_BEEF;
    tick();
    check_val("store_we", snap_mem_we, 32'd1);
    check_val("store_addr", snap_mem_addr, 32'h40);
    check_val("store_wdata", snap_mem_wdata, 32'hDEAD_BEEF);
    bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    tick(); tick(); tick();
    check_val("store_rvalid", snap_dm_rvalid, 32'd1);
    check_val("store_rdata", snap_dm_rdata, 32'd0);

    // Continuous contention: DM, DM, IF repeating.
    hold_both(18);
    check_val("starve_count", 32'(order_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < order_q.size(); i++) begin
      check_val($sformatf("starve_order%0d", i), 32'(order_q[i]), 32'(exp_order[i]));
    end
    tick(); tick(); tick();

    // Back-to-back loads at 0x0 and 0x4.
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0;
    tick();
    check_val("b2b_gnt0", snap_dm_gnt, 32'd1);
    bus.dm_addr = 32'h4;
    tick(); tick(); tick();
    check_val("b2b_gnt3", snap_dm_gnt, 32'd1);
    check_val("b2b_rvalid3", snap_dm_rvalid, 32'd1);
    check_val("b2b_addr3", snap_mem_addr, 32'h4);
    bus.dm_req = 1'b0;
    tick(); tick(); tick();

    // Reset in the first BUSY cycle of a fetch abandons it.
    bus.if_req = 1'b1; bus.if_addr = 32'h20;
    tick();
    bus.if_req = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("abandon_no_rvalid", snap_if_rvalid, 32'd0);
    end
    bus.if_req = 1'b1; bus.if_addr = 32'h24;
    tick();
    check_val("after_rst_gnt", snap_if_gnt, 32'd1);
    bus.if_req = 1'b0;
    tick(); tick(); tick();

    // Reset clears a non-zero starvation count.
    bus.dm_req = 1'b1; bus.if_req = 1'b1;
    tick();
    bus.dm_req = 1'b0; bus.if_req = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    hold_both(9);
    check_val("rst_starve_count", 32'(order_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < order_q.size(); i++) begin
      check_val($sformatf("rst_starve_order%0d", i), 32'(order_q[i]), 32'(exp_order[i]));
    end
    tick(); tick(); tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(99) == 0) rst_n = 1'b0;
      if (snap_if_gnt || !bus.if_req) begin
        bus.if_req  = ($urandom_range(99) < 60);
        bus.if_addr = $urandom();
      end else if ($urandom_range(99) < 5) begin
        bus.if_req = 1'b0;
      end
      if (snap_dm_gnt || !bus.dm_req) begin
        bus.dm_req   = ($urandom_range(99) < 60);
        bus.dm_we    = $urandom_range(1);
        bus.dm_addr  = $urandom();
        bus.dm_wdata = $urandom();
      end else if ($urandom_range(99) < 5) begin
        bus.dm_req = 1'b0;
      end
      tick();
    end
    rst_n = 1'b1;
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // MEM_LAT=1 instance: load completes two cycles after issue, next issue immediately.
    bus1.dm_req = 1'b1; bus1.dm_we = 1'b0; bus1.dm_addr = 32'h8;
    @(negedge clk);
    check_val("lat1_gnt0", bus1.dm_gnt, 32'd1);
    check_val("lat1_en0", bus1.mem_en, 32'd1);
    @(posedge clk); #1;
    bus1.dm_req = 1'b0; bus1.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    check_val("lat1_stall1", bus1.dm_stall, 32'd1);
    check_val("lat1_rvalid1", bus1.dm_rvalid, 32'd0);
    check_val("lat1_en1", bus1.mem_en, 32'd0);
    @(posedge clk); #1;
    bus1.dm_req = 1'b1; bus1.dm_addr = 32'hC; bus1.mem_rdata = 32'd0;
    @(negedge clk);
    check_val("lat1_rvalid2", bus1.dm_rvalid, 32'd1);
    check_val("lat1_rdata2", bus1.dm_rdata, 32'h1234_5678);
    check_val("lat1_gnt2", bus1.dm_gnt, 32'd1);
    check_val("lat1_stall2", bus1.dm_stall, 32'd0);
    @(posedge clk); #1;
    bus1.dm_req = 1'b0;
    @(negedge clk);
    check_val("lat1_rvalid3", bus1.dm_rvalid, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
